// File: rtl/single_ram_burst_if.sv
`default_nettype none
// ============================================================================
// Module      : single_ram_burst_if
// Description : Command, write-stream and read-stream bundle for the burst
//               RAM. The controller connects through the slave modport and
//               the requester through the master modport.
//   cmd_valid/cmd_ready/cmd_we/cmd_addr/cmd_len : burst command handshake
//   wr_valid/wr_ready/wr_data/wr_be             : write beat handshake
//   rd_valid/rd_data                            : read beat stream
//   busy/done                                   : burst status
// Revision    : 1.0 - initial release
// ============================================================================
interface single_ram_burst_if #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8,
  parameter int LEN_WIDTH     = 8
) ();
  logic                      cmd_valid;
  logic                      cmd_ready;
  logic                      cmd_we;
  logic [ADDRESS_WIDTH-1:0]  cmd_addr;
  logic [LEN_WIDTH-1:0]      cmd_len;
  logic                      wr_valid;
  logic                      wr_ready;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic [DATA_WIDTH/8-1:0]   wr_be;
  logic                      rd_valid;
  logic [DATA_WIDTH-1:0]     rd_data;
  logic                      busy;
  logic                      done;

  modport master (
    output cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, wr_be,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_we, cmd_addr, cmd_len, wr_valid, wr_data, wr_be,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/single_ram_burst.sv
`default_nettype none
// ============================================================================
// Module      : single_ram_burst
// Description : Single-port synchronous RAM with a burst controller. A
//               command gives start address, beat count minus one and
//               direction; the address auto-increments with wrap-around.
//               Write beats use a valid/ready handshake with byte-lane
//               enables; read beats stream out one per cycle with a single
//               registered cycle of latency.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (memory contents are kept)
//   bus  : single_ram_burst_if slave modport (command, write, read, status)
// Revision    : 1.0 - initial release
// ============================================================================
module single_ram_burst #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 8,
  parameter int RAM_DEPTH     = 1 << ADDRESS_WIDTH,
  parameter int LEN_WIDTH     = 8
) (
  input  logic              clk,
  input  logic              rst,
  single_ram_burst_if.slave bus
);

  localparam int c_NUM_LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [ADDRESS_WIDTH-1:0]  r_addr;
  logic [ADDRESS_WIDTH-1:0]  w_addr_nxt;
  logic [ADDRESS_WIDTH-1:0]  w_addr_inc;
  logic [LEN_WIDTH-1:0]      r_cnt;
  logic [LEN_WIDTH-1:0]      w_cnt_nxt;
  logic                      w_cnt_zero;
  logic                      w_mem_we;
  logic                      w_rd_en;
  logic                      w_last;
  logic                      r_rd_valid;
  logic [DATA_WIDTH-1:0]     r_rd_data;
  logic                      r_done;
  logic [DATA_WIDTH-1:0]     r_mem [RAM_DEPTH];

  // Depth is a power of two, so natural overflow of the address gives wrap.
  assign w_addr_inc = r_addr + 1'b1;
  assign w_cnt_zero = (r_cnt == '0);

  // --------------------------------------------------------------------------
  // State, address and count registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and per-cycle control
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cnt_nxt   = r_cnt;
    w_mem_we    = 1'b0;
    w_rd_en     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.cmd_valid) begin
          w_addr_nxt  = bus.cmd_addr;
          w_cnt_nxt   = bus.cmd_len;
          w_state_nxt = bus.cmd_we ? WRITE : READ;
        end
      end
      WRITE: begin
        // A missing beat simply stalls; address and count hold.
        if (bus.wr_valid) begin
          w_mem_we   = 1'b1;
          w_addr_nxt = w_addr_inc;
          if (w_cnt_zero) begin
            w_state_nxt = IDLE;
            w_last      = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
      end
      READ: begin
        w_rd_en    = 1'b1;
        w_addr_nxt = w_addr_inc;
        if (w_cnt_zero) begin
          w_state_nxt = IDLE;
          w_last      = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory array: byte-lane masked write, no reset on contents
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < c_NUM_LANES; i++) begin
      if (w_mem_we && bus.wr_be[i]) begin
        r_mem[r_addr][8*i +: 8] <= bus.wr_data[8*i +: 8];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Registered read port and completion pulse. done is registered off the
  // final beat so it lines up with the last rd_valid for reads and with the
  // first cycle the final write is visible for writes.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_en;
      r_done     <= w_last;
      if (w_rd_en) begin
        r_rd_data <= r_mem[r_addr];
      end
    end
  end

  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.wr_ready  = (r_state == WRITE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;
  assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_single_ram_burst.sv
`default_nettype none
// ============================================================================
// Module      : tb_single_ram_burst
// Description : Scoreboard bench for single_ram_burst. Stimulus tasks push the
//               expected read beats (data and cycle) and done cycles into
//               queues; a negedge monitor pops and compares whenever the DUT
//               shows rd_valid or done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_single_ram_burst;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   fails;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  int          done_q[$];
  logic [15:0] wq[$];
  logic [1:0]  bq[$];
  logic [15:0] eq[$];

  single_ram_burst_if #(.DATA_WIDTH(16), .ADDRESS_WIDTH(8), .LEN_WIDTH(8)) bus ();

  single_ram_burst #(
    .DATA_WIDTH   (16),
    .ADDRESS_WIDTH(8),
    .RAM_DEPTH    (256),
    .LEN_WIDTH    (8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every rd_valid and done must match the front of its queue.
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      vectors++;
      if (rd_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: got data %04h at cycle %0d, required no beat", bus.rd_data, cyc);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        if (bus.rd_data !== e.data || cyc != e.cyc) begin
          fails++;
          $display("FAIL rd_beat: got %04h at cycle %0d, required %04h at cycle %0d", bus.rd_data, cyc, e.data, e.cyc);
        end
      end
    end
    if (bus.done === 1'b1) begin
      vectors++;
      if (done_q.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected: got done at cycle %0d, required none", cyc);
      end else begin
        int d;
        d = done_q.pop_front();
        if (cyc != d) begin
          fails++;
          $display("FAIL done_cycle: got cycle %0d, required cycle %0d", cyc, d);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Present a command, wait for acceptance; t is the acceptance cycle.
  task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] len, output int t);
    int n;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      vectors++;
      fails++;
      $display("FAIL cmd_ready_timeout: got cmd_ready=%b, required 1", bus.cmd_ready);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    t = cyc;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  // Writes the beats in wq/bq; an optional stall of stall_n cycles follows
  // beat index stall_after. Returns in the done cycle.
  task automatic write_burst(input logic [7:0] a, input int stall_after, input int stall_n);
    int t;
    int n;
    n = wq.size();
    issue(1'b1, a, 8'(n - 1), t);
    done_q.push_back(t + n + 1 + ((stall_after >= 0) ? stall_n : 0));
    for (int k = 0; k < n; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = wq[k];
      bus.wr_be    = bq[k];
      tick();
      if (k == stall_after) begin
        bus.wr_valid = 1'b0;
        bus.wr_data  = 16'hDEAD;
        repeat (stall_n) tick();
      end
    end
    bus.wr_valid = 1'b0;
    wq.delete();
    bq.delete();
  endtask

  // Reads eq.size() beats expecting eq in order. Returns in the done cycle.
  task automatic read_burst(input logic [7:0] a);
    int t;
    int n;
    rd_exp_t e;
    n = eq.size();
    issue(1'b0, a, 8'(n - 1), t);
    for (int k = 0; k < n; k++) begin
      e.data = eq[k];
      e.cyc  = t + 2 + k;
      rd_q.push_back(e);
    end
    done_q.push_back(t + n + 1);
    eq.delete();
    repeat (n) tick();
  endtask

  initial begin
    int t;
    logic [7:0] kb;
    vectors       = 0;
    fails         = 0;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.wr_be     = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Reset state
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    check("rst_wr_ready",  32'(bus.wr_ready),  32'h0);
    check("rst_rd_valid",  32'(bus.rd_valid),  32'h0);
    check("rst_rd_data",   32'(bus.rd_data),   32'h0);
    check("rst_busy",      32'(bus.busy),      32'h0);
    check("rst_done",      32'(bus.done),      32'h0);

    // Basic 4-beat write then read, back to back
    wq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    bq = '{2'b11, 2'b11, 2'b11, 2'b11};
    write_burst(8'h10, -1, 0);
    eq = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    read_burst(8'h10);

    // Busy during a burst
    wq = '{16'h0BAD};
    bq = '{2'b11};
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_addr  = 8'h80;
    bus.cmd_len   = 8'd0;
    t = cyc;
    tick();
    bus.cmd_valid = 1'b0;
    check("busy_in_write", 32'(bus.busy), 32'h1);
    check("wr_ready_in_write", 32'(bus.wr_ready), 32'h1);
    check("cmd_ready_in_write", 32'(bus.cmd_ready), 32'h0);
    done_q.push_back(t + 2);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 16'h0BAD;
    bus.wr_be    = 2'b11;
    tick();
    bus.wr_valid = 1'b0;
    wq.delete();
    bq.delete();
    check("busy_after_done", 32'(bus.busy), 32'h0);

    // Address wrap
    wq = '{16'hA0A0, 16'hB1B1, 16'hC2C2};
    bq = '{2'b11, 2'b11, 2'b11};
    write_burst(8'hFE, -1, 0);
    eq = '{16'hA0A0, 16'hB1B1, 16'hC2C2};
    read_burst(8'hFE);
    eq = '{16'hC2C2};
    read_burst(8'h00);

    // Byte enables
    wq = '{16'hFFFF};
    bq = '{2'b11};
    write_burst(8'h20, -1, 0);
    wq = '{16'h1234};
    bq = '{2'b01};
    write_burst(8'h20, -1, 0);
    eq = '{16'hFF34};
    read_burst(8'h20);
    wq = '{16'h5678};
    bq = '{2'b00};
    write_burst(8'h20, -1, 0);
    eq = '{16'hFF34};
    read_burst(8'h20);

    // Write stall of 2 cycles between beats 1 and 2
    wq = '{16'h3A3A, 16'h3B3B, 16'h3C3C};
    bq = '{2'b11, 2'b11, 2'b11};
    write_burst(8'h30, 0, 2);
    eq = '{16'h3A3A, 16'h3B3B, 16'h3C3C};
    read_burst(8'h30);

    // Reset after 5 of 10 beats
    issue(1'b1, 8'h40, 8'd9, t);
    for (int k = 0; k < 5; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_data  = 16'h4000 + 16'(k);
      bus.wr_be    = 2'b11;
      tick();
    end
    bus.wr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_cmd_ready", 32'(bus.cmd_ready), 32'h1);
    check("abort_busy",      32'(bus.busy),      32'h0);
    check("abort_rd_valid",  32'(bus.rd_valid),  32'h0);
    check("abort_done",      32'(bus.done),      32'h0);
    tick();
    eq = '{16'h4000, 16'h4001, 16'h4002, 16'h4003, 16'h4004};
    read_burst(8'h40);

    // Max length: fill every address, read all 256, then a command in the done cycle
    for (int k = 0; k < 256; k++) begin
      kb = 8'(k);
      wq.push_back({kb, ~kb});
      bq.push_back(2'b11);
    end
    write_burst(8'h00, -1, 0);
    for (int k = 0; k < 256; k++) begin
      kb = 8'(k);
      eq.push_back({kb, ~kb});
    end
    read_burst(8'h00);
    check("maxlen_cmd_ready_in_done", 32'(bus.cmd_ready), 32'h1);
    eq = '{16'h10EF};
    read_burst(8'h10);

    repeat (5) tick();
    check("rd_queue_drained",   32'(rd_q.size()),   32'h0);
    check("done_queue_drained", 32'(done_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
`default_nettype wire
